pwm_demod: RTL and testbench



---
 rtl/pwm_pkg.sv | 16 +
 rtl/pwm_sync_edge.sv | 39 +++
 rtl/pwm_demod.sv | 184 ++++++++++++++++++
 tb/tb_pwm_demod.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg
// Definitions shared by the sine PWM modulator and the PWM demodulator:
// the nominal PWM period (in fabric clock cycles), the counter width, and
// the demodulator FSM state encoding.
package pwm_pkg;

   localparam int PWM_PERIOD = 1000;
   localparam int PWM_WIDTH  = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      TRACK   = 2'd2
   } pwm_state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// pwm_sync_edge
// Multi-flop synchronizer for an asynchronous single-bit input, followed by
// a rising-edge detector. Usable for any slow asynchronous level input.
//
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   async_in  in   asynchronous input bit
//   lvl       out  synchronized level (last synchronizer stage)
//   rise      out  one-cycle pulse: lvl is high now and was low last cycle
module pwm_sync_edge #(
   parameter int SYNC_STAGES = 2   // must be at least 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic lvl,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   lvl_d_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_reg  <= '0;
         lvl_d_reg <= 1'b0;
      end else begin
         sync_reg  <= {sync_reg[SYNC_STAGES-2:0], async_in};
         lvl_d_reg <= sync_reg[SYNC_STAGES-1];
      end
   end

   assign lvl  = sync_reg[SYNC_STAGES-1];
   // Combinational so that rise and lvl describe the same cycle; the high
   // counter relies on this alignment to count the rise cycle exactly once.
   assign rise = lvl & ~lvl_d_reg;

endmodule

// File: rtl/pwm_demod.sv
// pwm_demod
// PWM receiver: measures the high time and period of each PWM period of an
// asynchronous single-bit stream and publishes them once per period.
//
// Ports:
//   clk          in   fabric clock, all logic on its rising edge
//   rst_n        in   asynchronous active-low reset
//   en           in   enable; low forces the FSM to IDLE
//   pwm_in       in   PWM stream, asynchronous to clk
//   width_out    out  last published high-time count
//   width_valid  out  one-cycle strobe, width_out/period_out updated with it
//   period_out   out  last measured period length
//   period_err   out  one-cycle strobe: period outside PERIOD +/- TOL
//   timeout      out  one-cycle strobe: no rising edge for 2*PERIOD cycles
//   locked       out  high after LOCK_COUNT consecutive good periods
module pwm_demod
   import pwm_pkg::*;
#(
   parameter int PERIOD      = PWM_PERIOD,
   parameter int WIDTH       = PWM_WIDTH,
   parameter int TOL         = 2,
   parameter int LOCK_COUNT  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             pwm_in,
   output logic [WIDTH-1:0] width_out,
   output logic             width_valid,
   output logic [WIDTH-1:0] period_out,
   output logic             period_err,
   output logic             timeout,
   output logic             locked
);

   localparam logic [WIDTH-1:0] PERIOD_W    = WIDTH'(PERIOD);
   localparam logic [WIDTH-1:0] PERIOD_LO   = WIDTH'(PERIOD - TOL);
   localparam logic [WIDTH-1:0] PERIOD_HI   = WIDTH'(PERIOD + TOL);
   localparam logic [WIDTH-1:0] TIMEOUT_CNT = WIDTH'(2 * PERIOD);
   localparam logic [WIDTH-1:0] CNT_MAX     = '1;
   localparam logic [WIDTH-1:0] CNT_ONE     = WIDTH'(1);
   localparam int               GOOD_W      = $clog2(LOCK_COUNT + 1);
   localparam logic [GOOD_W-1:0] GOOD_MAX   = GOOD_W'(LOCK_COUNT);
   localparam logic [GOOD_W-1:0] GOOD_ONE   = GOOD_W'(1);

   logic lvl;
   logic rise;

   pwm_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync_edge (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (pwm_in),
      .lvl      (lvl),
      .rise     (rise)
   );

   pwm_state_e        state_reg;
   logic [WIDTH-1:0]  period_cnt_reg;
   logic [WIDTH-1:0]  high_cnt_reg;
   logic [GOOD_W-1:0] good_cnt_reg;
   logic [WIDTH-1:0]  width_out_reg;
   logic [WIDTH-1:0]  period_out_reg;
   logic              width_valid_reg;
   logic              period_err_reg;
   logic              timeout_reg;
   logic              locked_reg;

   // Saturating next values for the counters.
   logic [WIDTH-1:0]  period_cnt_next;
   logic [WIDTH-1:0]  high_cnt_next;
   logic [GOOD_W-1:0] good_cnt_next;
   logic              out_of_tol;

   always_comb begin
      period_cnt_next = period_cnt_reg;
      high_cnt_next   = high_cnt_reg;
      good_cnt_next   = good_cnt_reg;
      if (period_cnt_reg != CNT_MAX)
         period_cnt_next = period_cnt_reg + CNT_ONE;
      if (lvl && (high_cnt_reg != CNT_MAX))
         high_cnt_next = high_cnt_reg + CNT_ONE;
      if (good_cnt_reg != GOOD_MAX)
         good_cnt_next = good_cnt_reg + GOOD_ONE;
   end

   assign out_of_tol = (period_cnt_reg > PERIOD_HI) || (period_cnt_reg < PERIOD_LO);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         period_cnt_reg  <= '0;
         high_cnt_reg    <= '0;
         good_cnt_reg    <= '0;
         width_out_reg   <= '0;
         period_out_reg  <= '0;
         width_valid_reg <= 1'b0;
         period_err_reg  <= 1'b0;
         timeout_reg     <= 1'b0;
         locked_reg      <= 1'b0;
      end else begin
         width_valid_reg <= 1'b0;
         period_err_reg  <= 1'b0;
         timeout_reg     <= 1'b0;

         if (!en) begin
            // Published values are held; only tracking state is dropped.
            state_reg      <= IDLE;
            period_cnt_reg <= '0;
            high_cnt_reg   <= '0;
            good_cnt_reg   <= '0;
            locked_reg     <= 1'b0;
         end else begin
            case (state_reg)
               IDLE: begin
                  period_cnt_reg <= '0;
                  high_cnt_reg   <= '0;
                  state_reg      <= ACQUIRE;
               end

               ACQUIRE: begin
                  // First edge only starts a measurement; nothing published.
                  if (rise) begin
                     period_cnt_reg <= CNT_ONE;
                     high_cnt_reg   <= CNT_ONE;
                     state_reg      <= TRACK;
                  end else begin
                     period_cnt_reg <= period_cnt_next;
                     high_cnt_reg   <= high_cnt_next;
                  end
               end

               TRACK: begin
                  // A rise takes priority over the timeout threshold.
                  if (rise) begin
                     width_out_reg   <= high_cnt_reg;
                     period_out_reg  <= period_cnt_reg;
                     width_valid_reg <= 1'b1;
                     if (out_of_tol) begin
                        period_err_reg <= 1'b1;
                        good_cnt_reg   <= '0;
                        locked_reg     <= 1'b0;
                     end else begin
                        good_cnt_reg <= good_cnt_next;
                        if (good_cnt_next == GOOD_MAX)
                           locked_reg <= 1'b1;
                     end
                     period_cnt_reg <= CNT_ONE;
                     high_cnt_reg   <= CNT_ONE;
                  end else if (period_cnt_reg >= TIMEOUT_CNT) begin
                     // Constant level: report full-on as one nominal period.
                     width_out_reg   <= lvl ? PERIOD_W : '0;
                     period_out_reg  <= TIMEOUT_CNT;
                     width_valid_reg <= 1'b1;
                     timeout_reg     <= 1'b1;
                     good_cnt_reg    <= '0;
                     locked_reg      <= 1'b0;
                     period_cnt_reg  <= '0;
                     high_cnt_reg    <= '0;
                     state_reg       <= ACQUIRE;
                  end else begin
                     period_cnt_reg <= period_cnt_next;
                     high_cnt_reg   <= high_cnt_next;
                  end
               end

               default: begin
                  state_reg <= IDLE;
               end
            endcase
         end
      end
   end

   assign width_out   = width_out_reg;
   assign width_valid = width_valid_reg;
   assign period_out  = period_out_reg;
   assign period_err  = period_err_reg;
   assign timeout     = timeout_reg;
   assign locked      = locked_reg;

endmodule

// File: tb/tb_pwm_demod.sv
// tb_pwm_demod
// Table-driven bench for pwm_demod with a scoreboard queue: each period
// driven pushes the expected publish of the preceding period; a monitor
// pops and compares on every width_valid strobe.
module tb_pwm_demod;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        pwm_in;
   logic [31:0] width_out;
   logic        width_valid;
   logic [31:0] period_out;
   logic        period_err;
   logic        timeout;
   logic        locked;

   pwm_demod dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .pwm_in      (pwm_in),
      .width_out   (width_out),
      .width_valid (width_valid),
      .period_out  (period_out),
      .period_err  (period_err),
      .timeout     (timeout),
      .locked      (locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] w;
      logic [31:0] p;
      logic        err;
      logic        to;
      logic        lk;
   } exp_t;

   typedef struct {
      int h;
      int p;
      bit err;
   } vec_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model state
   bit          trk = 0;
   int          good = 0;
   bit          lk = 0;
   int          prev_h = 0;
   int          prev_p = 0;
   bit          prev_err = 0;
   logic [31:0] last_w = 0;
   logic [31:0] last_p = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int w, input int p, input bit err, input bit to);
      exp_t e;
      if (to || err) begin
         good = 0;
         lk = 0;
      end else begin
         if (good < 4) good++;
         lk = (good >= 4);
      end
      e.w = w; e.p = p; e.err = err; e.to = to; e.lk = lk;
      sb.push_back(e);
      last_w = w;
      last_p = p;
   endtask

   // Called at every driven rising edge: closes the previous period.
   task automatic model_rise(input int h, input int p, input bit err);
      if (trk) push_exp(prev_h, prev_p, prev_err, 1'b0);
      trk = 1;
      prev_h = h; prev_p = p; prev_err = err;
   endtask

   task automatic model_drop();
      trk = 0;
      good = 0;
      lk = 0;
   endtask

   task automatic drive_period(input int h, input int p, input bit err);
      model_rise(h, p, err);
      pwm_in = 1'b1;
      repeat (h) tick();
      pwm_in = 1'b0;
      repeat (p - h) tick();
   endtask

   task automatic timeout_seq(input bit level);
      model_rise(0, 0, 1'b0);
      model_drop();
      push_exp(level ? 1000 : 0, 2000, 1'b0, 1'b1);
      pwm_in = 1'b1;
      if (level) begin
         repeat (2300) tick();
      end else begin
         repeat (300) tick();
         pwm_in = 1'b0;
         repeat (2000) tick();
      end
      pwm_in = 1'b0;
      repeat (20) tick();
      check("locked_after_timeout", {31'd0, locked}, 32'd0);
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (rst_n && width_valid) begin
         if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_strobe: got width=%0d period=%0d expected no strobe", width_out, period_out);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("width_out", width_out, e.w);
            check("period_out", period_out, e.p);
            check("period_err", {31'd0, period_err}, {31'd0, e.err});
            check("timeout", {31'd0, timeout}, {31'd0, e.to});
            check("locked", {31'd0, locked}, {31'd0, e.lk});
            $display("strobe: width=%0d period=%0d err=%0b to=%0b locked=%0b", width_out, period_out, period_err, timeout, locked);
         end
      end else if (rst_n && (period_err || timeout)) begin
         errors++;
         checks++;
         $display("FAIL lone_flag: got err=%0b to=%0b expected both 0 without width_valid", period_err, timeout);
      end
   end

   vec_t vecs[18];

   initial begin
      vecs[0]  = '{300, 1000, 1'b0};
      vecs[1]  = '{300, 1000, 1'b0};
      vecs[2]  = '{300, 1000, 1'b0};
      vecs[3]  = '{300, 1000, 1'b0};
      vecs[4]  = '{300, 1000, 1'b0};
      vecs[5]  = '{300, 1000, 1'b0};
      vecs[6]  = '{450,  900, 1'b1};
      vecs[7]  = '{300, 1000, 1'b0};
      vecs[8]  = '{300, 1000, 1'b0};
      vecs[9]  = '{300, 1000, 1'b0};
      vecs[10] = '{300, 1000, 1'b0};
      vecs[11] = '{500, 1002, 1'b0};
      vecs[12] = '{500,  998, 1'b0};
      vecs[13] = '{500, 1003, 1'b1};
      vecs[14] = '{300, 2000, 1'b1};
      vecs[15] = '{300, 1000, 1'b0};
      vecs[16] = '{100, 1000, 1'b0};
      vecs[17] = '{700, 1000, 1'b0};

      rst_n  = 1'b0;
      en     = 1'b0;
      pwm_in = 1'b0;
      #1;
      check("reset_width_out", width_out, 32'd0);
      check("reset_period_out", period_out, 32'd0);
      check("reset_valid", {31'd0, width_valid}, 32'd0);
      check("reset_locked", {31'd0, locked}, 32'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      en = 1'b1;
      repeat (10) tick();

      for (int i = 0; i < 18; i++) begin
         drive_period(vecs[i].h, vecs[i].p, vecs[i].err);
      end

      // Constant high, then constant low after tracking
      timeout_seq(1'b1);
      drive_period(300, 1000, 1'b0);
      drive_period(300, 1000, 1'b0);
      timeout_seq(1'b0);
      drive_period(250, 1000, 1'b0);
      drive_period(250, 1000, 1'b0);
      drive_period(250, 1000, 1'b0);

      // Asynchronous reset in the low part of a period
      model_rise(0, 0, 1'b0);
      pwm_in = 1'b1;
      repeat (300) tick();
      pwm_in = 1'b0;
      repeat (200) tick();
      rst_n = 1'b0;
      #1;
      check("midreset_width_out", width_out, 32'd0);
      check("midreset_period_out", period_out, 32'd0);
      check("midreset_locked", {31'd0, locked}, 32'd0);
      model_drop();
      last_w = 0;
      last_p = 0;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (500) tick();
      drive_period(600, 1000, 1'b0);
      drive_period(600, 1000, 1'b0);
      drive_period(600, 1000, 1'b0);

      // Enable dropped in the low part of a period
      model_rise(0, 0, 1'b0);
      pwm_in = 1'b1;
      repeat (300) tick();
      pwm_in = 1'b0;
      repeat (200) tick();
      en = 1'b0;
      repeat (3) tick();
      check("endrop_width_out", width_out, last_w);
      check("endrop_period_out", period_out, last_p);
      check("endrop_locked", {31'd0, locked}, 32'd0);
      model_drop();
      en = 1'b1;
      repeat (500) tick();
      drive_period(400, 1000, 1'b0);
      drive_period(400, 1000, 1'b0);

      // Final rise closes the last driven period
      model_rise(0, 0, 1'b0);
      pwm_in = 1'b1;
      repeat (10) tick();
      pwm_in = 1'b0;
      for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
      check("scoreboard_drained", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
